lfsr_prng: RTL

LFSR_PRNG -- requirements
Module: lfsr_prng

---
 rtl/lfsr_pkg.sv | 63 ++++++
 rtl/lfsr_step.sv | 25 ++
 rtl/lfsr_prng.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random generator: the maximal-length
// tap table, the two-state FSM encoding and the single-shift reference function.
package lfsr_pkg;

  // state | meaning
  // PRIME | one bubble cycle after reset or load; rnd_valid low
  // RUN   | rnd holds a fresh word; rnd_valid high
  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } lfsr_state_e;

  localparam int unsigned MIN_W = 4;
  localparam int unsigned MAX_W = 32;

  // Maximal-length feedback masks for a Fibonacci left shift, indexed by width.
  // Bit k set means state bit k feeds the XOR that becomes the new LSB.
  // Entries below MIN_W are unused placeholders.
  localparam logic [31:0] MAX_TAPS [0:32] = '{
    32'h0000_0000,  // 0
    32'h0000_0000,  // 1
    32'h0000_0000,  // 2
    32'h0000_0000,  // 3
    32'h0000_000C,  // 4
    32'h0000_0014,  // 5
    32'h0000_0030,  // 6
    32'h0000_0060,  // 7
    32'h0000_00B8,  // 8
    32'h0000_0110,  // 9
    32'h0000_0240,  // 10
    32'h0000_0500,  // 11
    32'h0000_0829,  // 12
    32'h0000_100D,  // 13
    32'h0000_2015,  // 14
    32'h0000_6000,  // 15
    32'h0000_D008,  // 16
    32'h0001_2000,  // 17
    32'h0002_0400,  // 18
    32'h0004_0023,  // 19
    32'h0009_0000,  // 20
    32'h0014_0000,  // 21
    32'h0030_0000,  // 22
    32'h0042_0000,  // 23
    32'h00E1_0000,  // 24
    32'h0120_0000,  // 25
    32'h0200_0023,  // 26
    32'h0400_0013,  // 27
    32'h0900_0000,  // 28
    32'h1400_0000,  // 29
    32'h2000_0029,  // 30
    32'h4800_0000,  // 31
    32'h8020_0003   // 32
  };

  // One Fibonacci left shift on a 32-bit container. The caller keeps the low
  // N bits: the state above N is zero and taps above N are zero, so the
  // feedback is correct and the bit shifted into position N is simply dropped.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps);
    return {state[30:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational STEP-shift unroll of the LFSR, with a guard that replaces an
// all-zero result by all-ones so the generator can never lock up.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned   N     = 16,
  parameter int unsigned   STEP  = 1,
  parameter logic [N-1:0]  TAPS  = lfsr_pkg::MAX_TAPS[N][N-1:0]
) (
  input  logic [N-1:0] state_i,
  output logic [N-1:0] state_o
);

  logic [N-1:0] acc;

  // Apply STEP single shifts back to back, then apply the zero-state guard.
  always_comb begin
    acc = state_i;
    for (int unsigned i = 0; i < STEP; i++) begin
      acc = N'(lfsr_next(32'(acc), 32'(TAPS)));
    end
    state_o = (acc == '0) ? '1 : acc;
  end

endmodule

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random word source with a valid/ready output, seed loading,
// zero-seed repair and a wrap pulse when the sequence returns to its start.
// Optional feature: define LFSR_PERIOD_CNT_EN to add the period_len output
// and its 32-bit accept counter.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned   N     = 16,
  parameter int unsigned   STEP  = 1,
  parameter logic [N-1:0]  TAPS  = lfsr_pkg::MAX_TAPS[N][N-1:0]
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         rnd_ready,
  output logic         rnd_valid,
  output logic [N-1:0] rnd,
  output logic         wrap,
  output logic         seed_fixed
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [31:0]  period_len
`endif
);

  lfsr_state_e  fsm_q, fsm_d;
  logic [N-1:0] state_q, state_d;
  logic [N-1:0] start_q, start_d;
  logic         wrap_q, wrap_d;
  logic         seed_fixed_q, seed_fixed_d;
  logic [N-1:0] step_out;
  logic         accept;
  logic         seed_zero;
  logic         hit_start;

`ifdef LFSR_PERIOD_CNT_EN
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  period_q, period_d;
`endif

  lfsr_step #(
    .N    (N),
    .STEP (STEP),
    .TAPS (TAPS)
  ) u_step (
    .state_i (state_q),
    .state_o (step_out)
  );

  // Handshake decode; load always takes priority over an accept.
  always_comb begin
    accept    = (fsm_q == RUN) && rnd_ready && !load;
    seed_zero = (seed == '0);
    hit_start = (step_out == start_q);
  end

  // Next-state for the FSM, the LFSR state, the start register and the pulses.
  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    start_d      = start_q;
    wrap_d       = 1'b0;
    seed_fixed_d = 1'b0;
    if (load) begin
      state_d      = seed_zero ? '1 : seed;
      start_d      = seed_zero ? '1 : seed;
      seed_fixed_d = seed_zero;
      fsm_d        = PRIME;
    end else begin
      unique case (fsm_q)
        PRIME: fsm_d = RUN;
        RUN: begin
          if (accept) begin
            state_d = step_out;
            wrap_d  = hit_start;
          end
        end
        default: fsm_d = PRIME;
      endcase
    end
  end

  // Core registers; reset lands on the all-ones state with a priming bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= PRIME;
      state_q      <= '1;
      start_q      <= '1;
      wrap_q       <= 1'b0;
      seed_fixed_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      start_q      <= start_d;
      wrap_q       <= wrap_d;
      seed_fixed_q <= seed_fixed_d;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  // Count accepts since the last wrap or load; publish count+1 on each wrap.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (load) begin
      cnt_d = '0;
    end else if (accept) begin
      if (hit_start) begin
        period_d = (cnt_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : cnt_q + 32'd1;
        cnt_d    = '0;
      end else begin
        cnt_d = (cnt_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : cnt_q + 32'd1;
      end
    end
  end

  // Period counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period_len = period_q;
`endif

  // All outputs come straight from registers.
  assign rnd        = state_q;
  assign rnd_valid  = (fsm_q == RUN);
  assign wrap       = wrap_q;
  assign seed_fixed = seed_fixed_q;

endmodule
